// File: rtl/digital_clock.sv
`default_nettype none
// ============================================================================
// Module   : digital_clock
// Brief    : Free-running hours:minutes:seconds counter with a cycle prescaler.
// Revision : 1.0
// ============================================================================
module digital_clock #(
  parameter int TICKS_PER_SEC = 1,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours
);

  localparam int             c_PRE_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [5:0]     c_SEC_MAX  = 6'd59;
  localparam logic [5:0]     c_MIN_MAX  = 6'd59;
  localparam logic [4:0]     c_HOUR_MAX = 5'(HOURS_PER_DAY - 1);

  logic       w_tick;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;

  generate
    if (TICKS_PER_SEC > 1) begin : g_div
      localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICKS_PER_SEC - 1);
      logic [c_PRE_W-1:0] r_pre;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_pre <= '0;
        end else if (r_pre >= c_PRE_MAX) begin
          r_pre <= '0;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      assign w_tick = (r_pre >= c_PRE_MAX);
    end else begin : g_nodiv
      assign w_tick = 1'b1;
    end
  endgenerate

  // ">=" comparisons let any corrupted out-of-range value wrap back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
    end else if (w_tick) begin
      if (r_sec >= c_SEC_MAX) begin
        r_sec <= '0;
        if (r_min >= c_MIN_MAX) begin
          r_min <= '0;
          if (r_hour >= c_HOUR_MAX) begin
            r_hour <= '0;
          end else begin
            r_hour <= r_hour + 5'd1;
          end
        end else begin
          r_min <= r_min + 6'd1;
        end
      end else begin
        r_sec <= r_sec + 6'd1;
      end
    end
  end

  assign seconds = r_sec;
  assign minutes = r_min;
  assign hours   = r_hour;

endmodule
`default_nettype wire

// File: tb/tb_digital_clock.sv
`default_nettype none
// ============================================================================
// Module   : tb_digital_clock
// Brief    : Scoreboard bench for digital_clock (default, short-day, prescaled).
// Revision : 1.0
// ============================================================================
module tb_digital_clock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
  logic [5:0] s0, m0, s3, m3, s4, m4;
  logic [4:0] h0, h3, h4;

  digital_clock dut0 (.clk(clk), .rst(rst0), .seconds(s0), .minutes(m0), .hours(h0));
  digital_clock #(.TICKS_PER_SEC(1), .HOURS_PER_DAY(3)) dut3
    (.clk(clk), .rst(rst3), .seconds(s3), .minutes(m3), .hours(h3));
  digital_clock #(.TICKS_PER_SEC(4), .HOURS_PER_DAY(24)) dut4
    (.clk(clk), .rst(rst4), .seconds(s4), .minutes(m4), .hours(h4));

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] q0[$];
  logic [16:0] q3[$];
  logic [16:0] q4[$];
  logic [16:0] t0, t3, t4, exp_v, got;
  int          p4;

  // Reference model: advance {hh,mm,ss} by one second via total-seconds arithmetic.
  function automatic logic [16:0] adv(input logic [16:0] t, input int hmod);
    int tot;
    tot = int'(t[16:12]) * 3600 + int'(t[11:6]) * 60 + int'(t[5:0]);
    tot = (tot + 1) % (hmod * 3600);
    return {5'(tot / 3600), 6'((tot / 60) % 60), 6'(tot % 60)};
  endfunction

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    t0 = '0;
    q0.push_back(t0);
    edge_wait();
    exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", got, exp_v); end
    got = {h3, m3, s3}; n_tests++;
    if (got !== 17'd0) begin n_fail++; $display("FAIL reset_held_dut3 got=%h exp=%h", got, 17'd0); end
    got = {h4, m4, s4}; n_tests++;
    if (got !== 17'd0) begin n_fail++; $display("FAIL reset_held_dut4 got=%h exp=%h", got, 17'd0); end
    rst0 = 1'b0;
    repeat (3) begin
      t0 = adv(t0, 24); q0.push_back(t0);
      edge_wait();
      exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL post_reset_count got=%h exp=%h", got, exp_v); end
    end
    got = {h0, m0, s0}; n_tests++;
    if (got !== {5'd0, 6'd0, 6'd3}) begin n_fail++; $display("FAIL third_second got=%h exp=%h", got, {5'd0, 6'd0, 6'd3}); end
  endtask

  task automatic test_minute_rollover();
    repeat (56) begin
      t0 = adv(t0, 24); q0.push_back(t0);
      edge_wait();
      exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL seconds_count got=%h exp=%h", got, exp_v); end
    end
    got = {h0, m0, s0}; n_tests++;
    if (got !== {5'd0, 6'd0, 6'd59}) begin n_fail++; $display("FAIL sec_59 got=%h exp=%h", got, {5'd0, 6'd0, 6'd59}); end
    edge_wait();
    got = {h0, m0, s0}; n_tests++;
    if (got !== {5'd0, 6'd1, 6'd0}) begin n_fail++; $display("FAIL minute_roll got=%h exp=%h", got, {5'd0, 6'd1, 6'd0}); end
    t0 = adv(t0, 24);
  endtask

  task automatic test_hour_rollover();
    repeat (3539) begin
      t0 = adv(t0, 24); q0.push_back(t0);
      edge_wait();
      exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL hour_run got=%h exp=%h", got, exp_v); end
    end
    got = {h0, m0, s0}; n_tests++;
    if (got !== {5'd0, 6'd59, 6'd59}) begin n_fail++; $display("FAIL at_00_59_59 got=%h exp=%h", got, {5'd0, 6'd59, 6'd59}); end
    edge_wait();
    got = {h0, m0, s0}; n_tests++;
    if (got !== {5'd1, 6'd0, 6'd0}) begin n_fail++; $display("FAIL hour_roll got=%h exp=%h", got, {5'd1, 6'd0, 6'd0}); end
  endtask

  task automatic test_reset_mid();
    rst0 = 1'b1; t0 = '0; q0.push_back(t0);
    edge_wait();
    exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
    if (got !== exp_v) begin n_fail++; $display("FAIL mid_reset_pre got=%h exp=%h", got, exp_v); end
    rst0 = 1'b0;
    repeat (2) begin
      t0 = adv(t0, 24); q0.push_back(t0);
      edge_wait();
      exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL mid_count got=%h exp=%h", got, exp_v); end
    end
    rst0 = 1'b1; t0 = '0;
    repeat (2) begin
      q0.push_back(t0);
      edge_wait();
      exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL mid_reset_hold got=%h exp=%h", got, exp_v); end
    end
    rst0 = 1'b0;
    t0 = adv(t0, 24); q0.push_back(t0);
    edge_wait();
    exp_v = q0.pop_front(); got = {h0, m0, s0}; n_tests++;
    if (got !== exp_v) begin n_fail++; $display("FAIL mid_resume got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_day_wrap();
    rst3 = 1'b0; t3 = '0;
    repeat (10799) begin
      t3 = adv(t3, 3); q3.push_back(t3);
      edge_wait();
      exp_v = q3.pop_front(); got = {h3, m3, s3}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL day_run got=%h exp=%h", got, exp_v); end
    end
    got = {h3, m3, s3}; n_tests++;
    if (got !== {5'd2, 6'd59, 6'd59}) begin n_fail++; $display("FAIL day_last got=%h exp=%h", got, {5'd2, 6'd59, 6'd59}); end
    edge_wait();
    got = {h3, m3, s3}; n_tests++;
    if (got !== 17'd0) begin n_fail++; $display("FAIL day_wrap got=%h exp=%h", got, 17'd0); end
    edge_wait();
    got = {h3, m3, s3}; n_tests++;
    if (got !== 17'd1) begin n_fail++; $display("FAIL day_wrap_next got=%h exp=%h", got, 17'd1); end
  endtask

  task automatic test_prescaler();
    rst4 = 1'b0; t4 = '0; p4 = 0;
    for (int i = 0; i < 240; i++) begin
      if (p4 == 3) t4 = adv(t4, 24);
      p4 = (p4 + 1) % 4;
      q4.push_back(t4);
      edge_wait();
      exp_v = q4.pop_front(); got = {h4, m4, s4}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL prescale_run cyc=%0d got=%h exp=%h", i, got, exp_v); end
      if (i == 2) begin
        n_tests++;
        if (s4 !== 6'd0) begin n_fail++; $display("FAIL prescale_hold got=%0d exp=0", s4); end
      end
      if (i == 3) begin
        n_tests++;
        if (s4 !== 6'd1) begin n_fail++; $display("FAIL prescale_first got=%0d exp=1", s4); end
      end
    end
    got = {h4, m4, s4}; n_tests++;
    if (got !== {5'd0, 6'd1, 6'd0}) begin n_fail++; $display("FAIL prescale_minute got=%h exp=%h", got, {5'd0, 6'd1, 6'd0}); end
  endtask

  initial begin
    test_reset();
    test_minute_rollover();
    test_hour_rollover();
    test_reset_mid();
    test_day_wrap();
    test_prescaler();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
